// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - memory-stage to request/addr_ok/data_ok data bus bridge
module dmem_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        pipe_hold,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;

  logic        in_wr;
  logic [1:0]  in_size;
  logic [31:0] in_addr;

  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;

  logic        issue;

  assign issue   = (state == S_IDLE) && cpu_en;
  assign in_wr   = |cpu_wen;
  assign in_addr = in_wr ? cpu_addr : {cpu_addr[31:2], 2'b00};

  // Only the four single-lane and two aligned half-word strobes are narrow; everything else is a word
  always_comb begin
    in_size = 2'd2;
    case (cpu_wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: in_size = 2'd0;
      4'b0011, 4'b1100:                   in_size = 2'd1;
      default:                            in_size = 2'd2;
    endcase
  end

  // Fields are live from the stage only while issuing; zero when idle; latched copies afterwards
  always_comb begin
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = 32'd0;
    data_wstrb = 4'd0;
    data_wdata = 32'd0;
    if (issue) begin
      data_wr    = in_wr;
      data_size  = in_size;
      data_addr  = in_addr;
      data_wstrb = cpu_wen;
      data_wdata = cpu_wdata;
    end else if (state != S_IDLE) begin
      data_wr    = r_wr;
      data_size  = r_size;
      data_addr  = r_addr;
      data_wstrb = r_wstrb;
      data_wdata = r_wdata;
    end
  end

  assign data_req  = issue || (state == S_REQ);
  assign cpu_stall = cpu_en && (state != S_DONE);

  // Next-state: bus progress is independent of pipe_hold until the access is done
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cpu_en) state_nxt = data_addr_ok ? S_WAIT : S_REQ;
      S_REQ:  if (data_addr_ok) state_nxt = S_WAIT;
      S_WAIT: if (data_data_ok) state_nxt = S_DONE;
      S_DONE: if (!pipe_hold) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Capture the request fields on the issue cycle so they stay stable through REQ/WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'd0;
      r_wstrb <= 4'd0;
      r_wdata <= 32'd0;
    end else if (issue) begin
      r_wr    <= in_wr;
      r_size  <= in_size;
      r_addr  <= in_addr;
      r_wstrb <= cpu_wen;
      r_wdata <= cpu_wdata;
    end
  end

  // Load word is captured once on completion and held until the next load completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         cpu_rdata <= 32'd0;
    else if ((state == S_WAIT) && data_data_ok && !r_wr) cpu_rdata <= data_rdata;
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - directed scoreboard bench for dmem_bridge
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        pipe_hold;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  dmem_bridge dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .pipe_hold(pipe_hold), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then settle before checking
  task automatic cyc(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic hold, input logic aok,
                     input logic dok, input logic [31:0] rd);
    @(negedge clk);
    cpu_en = en; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
    pipe_hold = hold; data_addr_ok = aok; data_data_ok = dok; data_rdata = rd;
    #1;
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_stall"}, {31'd0, cpu_stall}, 32'd0);
    n_tests++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (exp_q.size() > 0) chk({tag, "_rdata"}, cpu_rdata, exp_q.pop_front());
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdata"}, cpu_rdata, 32'd0);
    chk({tag, "_stall"}, {31'd0, cpu_stall}, 32'd0);
    chk({tag, "_req"},   {31'd0, data_req}, 32'd0);
    chk({tag, "_wr"},    {31'd0, data_wr}, 32'd0);
    chk({tag, "_size"},  {30'd0, data_size}, 32'd0);
    chk({tag, "_addr"},  data_addr, 32'd0);
    chk({tag, "_wstrb"}, {28'd0, data_wstrb}, 32'd0);
    chk({tag, "_wdata"}, data_wdata, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    cpu_en = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0; pipe_hold = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    #2;
    chk_zero("reset");
    @(negedge clk); rst = 1'b1;

    // Load word, minimum latency
    cyc(1, 4'b0000, 32'h1000_0006, 32'h0, 0, 1, 0, 32'h0);
    exp_q.push_back(32'hDEAD_BEEF);
    chk("ld_req",   {31'd0, data_req}, 32'd1);
    chk("ld_addr",  data_addr, 32'h1000_0004);
    chk("ld_size",  {30'd0, data_size}, 32'd2);
    chk("ld_wr",    {31'd0, data_wr}, 32'd0);
    chk("ld_stall0", {31'd0, cpu_stall}, 32'd1);
    cyc(1, 4'b0000, 32'h1000_0006, 32'h0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("ld_stall1", {31'd0, cpu_stall}, 32'd1);
    chk("ld_req1",   {31'd0, data_req}, 32'd0);
    cyc(1, 4'b0000, 32'h1000_0006, 32'h0, 0, 0, 0, 32'h0);
    chk_done("ld");
    cyc(0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    chk("ld_idle_req", {31'd0, data_req}, 32'd0);

    // Store byte, addr_ok delayed; stage inputs perturbed to prove fields are latched
    for (int i = 0; i < 4; i++) begin
      if (i == 0) cyc(1, 4'b0100, 32'h0000_0011, 32'h5A5A_5A5A, 0, 0, 0, 32'h0);
      else        cyc(1, 4'b1111, 32'hFFFF_FFF0 + i, 32'h1234_0000 + i, 0, (i == 3), 0, 32'h0);
      chk($sformatf("sb_req%0d", i),   {31'd0, data_req}, 32'd1);
      chk($sformatf("sb_addr%0d", i),  data_addr, 32'h0000_0011);
      chk($sformatf("sb_size%0d", i),  {30'd0, data_size}, 32'd0);
      chk($sformatf("sb_wstrb%0d", i), {28'd0, data_wstrb}, 32'h4);
      chk($sformatf("sb_wr%0d", i),    {31'd0, data_wr}, 32'd1);
      chk($sformatf("sb_wdata%0d", i), data_wdata, 32'h5A5A_5A5A);
      chk($sformatf("sb_stall%0d", i), {31'd0, cpu_stall}, 32'd1);
    end
    exp_q.push_back(32'hDEAD_BEEF);
    cyc(1, 4'b0100, 32'h0000_0011, 32'h5A5A_5A5A, 0, 0, 1, 32'h7777_7777);
    chk("sb_wait_req", {31'd0, data_req}, 32'd0);
    cyc(1, 4'b0100, 32'h0000_0011, 32'h5A5A_5A5A, 0, 0, 0, 32'h0);
    chk_done("sb");

    // Store halfword
    cyc(1, 4'b0011, 32'h0000_0020, 32'hABCD_ABCD, 0, 1, 0, 32'h0);
    chk("sh_size", {30'd0, data_size}, 32'd1);
    chk("sh_wr",   {31'd0, data_wr}, 32'd1);
    chk("sh_addr", data_addr, 32'h0000_0020);
    exp_q.push_back(32'hDEAD_BEEF);
    cyc(1, 4'b0011, 32'h0000_0020, 32'hABCD_ABCD, 0, 0, 1, 32'h0);
    cyc(1, 4'b0011, 32'h0000_0020, 32'hABCD_ABCD, 0, 0, 0, 32'h0);
    chk_done("sh");

    // Illegal strobe passes through as a word
    cyc(1, 4'b0110, 32'h0000_0031, 32'h0, 0, 1, 0, 32'h0);
    chk("il_size", {30'd0, data_size}, 32'd2);
    chk("il_addr", data_addr, 32'h0000_0031);
    cyc(1, 4'b0110, 32'h0000_0031, 32'h0, 0, 1, 1, 32'h0);
    cyc(1, 4'b0110, 32'h0000_0031, 32'h0, 0, 0, 0, 32'h0);
    chk("il_stall", {31'd0, cpu_stall}, 32'd0);

    // Load completing under pipe_hold; spurious addr_ok/data_ok are ignored
    cyc(1, 4'b0000, 32'h0000_0044, 32'h0, 0, 1, 0, 32'h0);
    exp_q.push_back(32'h1234_5678);
    cyc(1, 4'b0000, 32'h0000_0044, 32'h0, 1, 1, 1, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 4'b0000, 32'h0000_0044, 32'h0, 1, 1, 1, 32'hBAD0_0000 + i);
      chk($sformatf("ph_rdata%0d", i), cpu_rdata, 32'h1234_5678);
      chk($sformatf("ph_stall%0d", i), {31'd0, cpu_stall}, 32'd0);
      chk($sformatf("ph_req%0d", i),   {31'd0, data_req}, 32'd0);
    end
    cyc(1, 4'b0000, 32'h0000_0044, 32'h0, 0, 0, 0, 32'h0);
    chk_done("ph");
    // Back-to-back load issues in the IDLE cycle after hold falls
    cyc(1, 4'b0000, 32'h0000_0049, 32'h0, 0, 1, 0, 32'h0);
    chk("b2b_req",   {31'd0, data_req}, 32'd1);
    chk("b2b_stall", {31'd0, cpu_stall}, 32'd1);
    chk("b2b_addr",  data_addr, 32'h0000_0048);
    exp_q.push_back(32'hCAFE_F00D);
    cyc(1, 4'b0000, 32'h0000_0049, 32'h0, 0, 0, 1, 32'hCAFE_F00D);
    cyc(1, 4'b0000, 32'h0000_0049, 32'h0, 0, 0, 0, 32'h0);
    chk_done("b2b");

    // Reset during WAIT
    cyc(1, 4'b0000, 32'h0000_0080, 32'h0, 0, 1, 0, 32'h0);
    cyc(1, 4'b0000, 32'h0000_0080, 32'h0, 0, 0, 0, 32'h0);
    chk("rw_stall", {31'd0, cpu_stall}, 32'd1);
    #1;
    rst = 1'b0;
    cpu_en = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0;
    #1;
    chk_zero("rst_wait");
    @(negedge clk); rst = 1'b1;
    cyc(1, 4'b0000, 32'h0000_0100, 32'h0, 0, 1, 0, 32'h0);
    chk("post_req",  {31'd0, data_req}, 32'd1);
    chk("post_addr", data_addr, 32'h0000_0100);
    exp_q.push_back(32'h0BAD_CAFE);
    cyc(1, 4'b0000, 32'h0000_0100, 32'h0, 0, 0, 1, 32'h0BAD_CAFE);
    cyc(1, 4'b0000, 32'h0000_0100, 32'h0, 0, 0, 0, 32'h0);
    chk_done("post");
    cyc(0, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
